// File: rtl/uart_tx_stream_pkg.sv
// Shared UART definitions: baud divisor helper (also used by the receiver)
// and the transmit FSM state encoding.
package uart_tx_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per bit; integer division, so the baud error is truncation.
  function automatic int calc_n_ticks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period counter: counts 0..N_TICKS-1 and flags the last tick of each bit.
module uart_baud_timer #(
  parameter int N_TICKS = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = $clog2(N_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// Stream-fed UART transmitter with a one-word holding register so that
// consecutive frames leave the line with no idle gap.
module uart_tx_stream
  import uart_tx_stream_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int N_BITS    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] uart_tx_tdata,
  input  logic              uart_tx_tvalid,
  output logic              uart_tx_tready,
  output logic              tx_data,
  output logic              tx_busy,
  output tx_state_e         state_dbg
);

  localparam int N_TICKS = calc_n_ticks(CLK_FREQ, BAUD_RATE);
  localparam int IW = $clog2(N_BITS + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(N_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e         state, state_n;
  logic [N_BITS-1:0] hold, hold_n, shifter, shifter_n;
  logic [IW-1:0]     bit_idx, bit_idx_n;
  logic              hold_full, hold_full_n;
  logic              stop_idx, stop_idx_n;
  logic              tx_data_n, load, accept, bit_done, timer_restart;

  // Handshake: a word transfers on a rising edge where tvalid && tready;
  // tready only means the holding register is empty and never depends on tvalid.
  assign uart_tx_tready = ~hold_full & ~rst;
  assign accept         = uart_tx_tvalid & uart_tx_tready;
  assign state_dbg      = state;

  uart_baud_timer #(.N_TICKS(N_TICKS)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (timer_restart),
    .bit_done (bit_done)
  );

  always_comb begin
    state_n       = state;
    hold_n        = hold;
    hold_full_n   = hold_full;
    shifter_n     = shifter;
    bit_idx_n     = bit_idx;
    stop_idx_n    = stop_idx;
    load          = 1'b0;
    timer_restart = (state == IDLE);
    tx_data_n     = 1'b1;

    case (state)
      IDLE:  load = hold_full;
      START: if (bit_done) state_n = DATA;
      DATA: begin
        if (bit_done) begin
          shifter_n = shifter >> 1;
          if (bit_idx == LAST_BIT) begin
            state_n    = STOP;
            bit_idx_n  = '0;
            stop_idx_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (stop_idx == LAST_STOP) begin
            if (hold_full) load = 1'b1;
            else           state_n = IDLE;
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Loading frees the holding register; an accept on the same edge refills it.
    if (load) begin
      shifter_n     = hold;
      hold_full_n   = 1'b0;
      state_n       = START;
      bit_idx_n     = '0;
      stop_idx_n    = 1'b0;
      timer_restart = 1'b1;
    end
    if (accept) begin
      hold_n      = uart_tx_tdata;
      hold_full_n = 1'b1;
    end

    case (state_n)
      START:   tx_data_n = 1'b0;
      DATA:    tx_data_n = shifter_n[0];
      default: tx_data_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shifter   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      tx_data   <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      shifter   <= shifter_n;
      bit_idx   <= bit_idx_n;
      stop_idx  <= stop_idx_n;
      tx_data   <= tx_data_n;
      tx_busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: exact line timing on a default-rate instance,
// plus loopback through a sampling receiver model at a fast baud rate.
module tb_uart_tx_stream;

  localparam int NT_A = 25_000_000 / 115200;
  localparam int F_A  = 10 * NT_A;
  localparam int NT_B = 4;
  localparam int MAXC = 40000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // default-rate instance
  logic [7:0] a_tdata  = '0;
  logic       a_tvalid = 1'b0;
  logic       a_tready, a_tx, a_busy;
  uart_tx_stream_pkg::tx_state_e a_state;

  uart_tx_stream u_dut_a (
    .clk(clk), .rst(rst), .uart_tx_tdata(a_tdata), .uart_tx_tvalid(a_tvalid),
    .uart_tx_tready(a_tready), .tx_data(a_tx), .tx_busy(a_busy), .state_dbg(a_state)
  );

  // fast instances, index 0: one stop bit, index 1: two stop bits
  logic [7:0] b_tdata[2];
  logic       b_tvalid[2];
  logic       b_tready[2];
  logic       b_tx[2];
  logic       b_busy[2];
  uart_tx_stream_pkg::tx_state_e b_state[2];

  uart_tx_stream #(.CLK_FREQ(400), .BAUD_RATE(100), .N_BITS(8), .STOP_BITS(1)) u_dut_b1 (
    .clk(clk), .rst(rst), .uart_tx_tdata(b_tdata[0]), .uart_tx_tvalid(b_tvalid[0]),
    .uart_tx_tready(b_tready[0]), .tx_data(b_tx[0]), .tx_busy(b_busy[0]), .state_dbg(b_state[0])
  );
  uart_tx_stream #(.CLK_FREQ(400), .BAUD_RATE(100), .N_BITS(8), .STOP_BITS(2)) u_dut_b2 (
    .clk(clk), .rst(rst), .uart_tx_tdata(b_tdata[1]), .uart_tx_tvalid(b_tvalid[1]),
    .uart_tx_tready(b_tready[1]), .tx_data(b_tx[1]), .tx_busy(b_busy[1]), .state_dbg(b_state[1])
  );

  // per-cycle log of instance A, value after edge number c
  logic line_a[MAXC];
  logic busy_a[MAXC];
  logic rdy_a[MAXC];
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      line_a[cyc] = a_tx;
      busy_a[cyc] = a_busy;
      rdy_a[cyc]  = a_tready;
    end
  end

  // reference model of instance A: list of frames (start cycle, word)
  int         fs[$];
  logic [7:0] fw[$];
  int         last_end = 0;
  logic [7:0] exp_q[$];

  function automatic void model_push(input logic [7:0] w, input int hs);
    int s;
    s = (hs + 1 > last_end) ? hs + 1 : last_end;
    fs.push_back(s);
    fw.push_back(w);
    last_end = s + F_A;
  endfunction

  // expected {busy, line} after edge c
  function automatic logic [1:0] exp_sig(input int c);
    for (int i = 0; i < fs.size(); i++) begin
      if (c >= fs[i] && c < fs[i] + F_A) begin
        int b;
        b = (c - fs[i]) / NT_A;
        if (b == 0) return 2'b10;
        if (b <= 8) return {1'b1, fw[i][b-1]};
        return 2'b11;
      end
    end
    return 2'b01;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_push(input logic [7:0] w, output int hs);
    int n;
    n = 0;
    a_tvalid = 1'b1;
    a_tdata  = w;
    while (a_tready !== 1'b1 && n < 3 * F_A) begin
      tick(1);
      n++;
    end
    tick(1);
    hs = cyc;
    total++;
    if (n >= 3 * F_A) begin
      bad++;
      $display("FAIL push_timeout: waited %0d cycles, required < %0d", n, 3 * F_A);
    end
    model_push(w, hs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++;
    if ({a_tx, a_busy, a_tready} !== 3'b100) begin
      bad++;
      $display("FAIL reset_outputs: tx,busy,tready=%b required 100", {a_tx, a_busy, a_tready});
    end
    rst = 1'b0;
    tick(1);
    total++;
    if (a_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_tready: got %b required 1", a_tready);
    end
  endtask

  task automatic test_idle();
    int t0, e_line, e_busy, e_rdy;
    t0 = cyc;
    e_line = 0; e_busy = 0; e_rdy = 0;
    tick(10000);
    for (int c = t0; c < cyc; c++) begin
      if (line_a[c] !== 1'b1) e_line++;
      if (busy_a[c] !== 1'b0) e_busy++;
      if (rdy_a[c] !== 1'b1) e_rdy++;
    end
    total++;
    if (e_line != 0) begin bad++; $display("FAIL idle_line: %0d cycles not 1, required 0", e_line); end
    total++;
    if (e_busy != 0) begin bad++; $display("FAIL idle_busy: %0d cycles busy, required 0", e_busy); end
    total++;
    if (e_rdy != 0) begin bad++; $display("FAIL idle_tready: %0d cycles not ready, required 0", e_rdy); end
  endtask

  task automatic test_single();
    int hs, errs;
    logic [9:0] pat;
    pat = 10'b10_1010_1010;
    a_push(8'h55, hs);
    a_tvalid = 1'b0;
    tick(F_A + 3);
    total++;
    if ({line_a[hs], line_a[hs+1], busy_a[hs], busy_a[hs+1]} !== 4'b1001) begin
      bad++;
      $display("FAIL single_latency: line,line+1,busy,busy+1=%b required 1001",
               {line_a[hs], line_a[hs+1], busy_a[hs], busy_a[hs+1]});
    end
    errs = 0;
    for (int j = 0; j < 10; j++)
      if (line_a[hs + 1 + j * NT_A + NT_A / 2] !== pat[j]) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL single_pattern: %0d bad bits, required 0", errs); end
    total++;
    if ({busy_a[hs + F_A], busy_a[hs + 1 + F_A]} !== 2'b10) begin
      bad++;
      $display("FAIL single_busy_end: got %b required 10", {busy_a[hs + F_A], busy_a[hs + 1 + F_A]});
    end
    errs = 0;
    for (int c = hs; c < cyc; c++)
      if ({busy_a[c], line_a[c]} !== exp_sig(c)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL single_wave: %0d cycles differ, required 0", errs); end
  endtask

  task automatic test_back_to_back();
    int h1, h2, errs;
    a_push(8'hA5, h1);
    a_push(8'h3C, h2);
    a_tvalid = 1'b0;
    total++;
    if (h2 !== h1 + 2) begin bad++; $display("FAIL b2b_second_hs: got %0d required %0d", h2 - h1, 2); end
    tick(2 * F_A + 3);
    total++;
    if ({line_a[h1 + F_A], line_a[h1 + 1 + F_A]} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_second_start: got %b required 10", {line_a[h1 + F_A], line_a[h1 + 1 + F_A]});
    end
    errs = 0;
    for (int c = h1; c < cyc; c++)
      if ({busy_a[c], line_a[c]} !== exp_sig(c)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL b2b_wave: %0d cycles differ, required 0", errs); end
  endtask

  task automatic test_backpressure();
    int h1, h2, h3, errs;
    a_push(8'h01, h1);
    a_push(8'h02, h2);
    a_push(8'h03, h3);
    a_tvalid = 1'b0;
    total++;
    if ({h2 - h1, h3 - h1} !== {32'd2, 32'(F_A + 2)}) begin
      bad++;
      $display("FAIL bp_handshakes: got +%0d,+%0d required +2,+%0d", h2 - h1, h3 - h1, F_A + 2);
    end
    tick(3 * F_A + 3);
    errs = 0;
    for (int c = h2; c <= h1 + F_A; c++)
      if (rdy_a[c] !== 1'b0) errs++;
    if (rdy_a[h1 + F_A + 1] !== 1'b1) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL bp_tready: %0d cycles wrong, required 0", errs); end
    errs = 0;
    for (int c = h1; c < cyc; c++)
      if ({busy_a[c], line_a[c]} !== exp_sig(c)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL bp_wave: %0d cycles differ, required 0", errs); end
  endtask

  task automatic test_reset_mid();
    int h1, h2, t0, errs;
    a_push(8'hF0, h1);
    a_push(8'h77, h2);
    a_tvalid = 1'b0;
    tick(h1 + 1 + 3 * NT_A + NT_A / 2 - cyc);
    total++;
    if (a_tx !== 1'b0) begin bad++; $display("FAIL rstmid_pre: tx=%b required 0", a_tx); end
    rst = 1'b1;
    tick(1);
    total++;
    if ({a_tx, a_busy, a_tready} !== 3'b100) begin
      bad++;
      $display("FAIL rstmid_edge: tx,busy,tready=%b required 100", {a_tx, a_busy, a_tready});
    end
    t0 = cyc;
    tick(2);
    total++;
    if (a_tready !== 1'b0) begin bad++; $display("FAIL rstmid_tready: got %b required 0", a_tready); end
    rst = 1'b0;
    fs.delete();
    fw.delete();
    last_end = 0;
    tick(F_A + 20);
    errs = 0;
    for (int c = t0; c < cyc; c++)
      if ({busy_a[c], line_a[c]} !== 2'b01) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL rstmid_after: %0d cycles not idle, required 0", errs); end
  endtask

  task automatic test_loopback(input int k, input int sb);
    fork
      begin : drv
        for (int w = 0; w < 256; w++) begin
          int g, n;
          g = $urandom_range(0, 3);
          repeat (g) begin
            b_tvalid[k] = 1'b0;
            b_tdata[k]  = 8'($urandom);
            tick(1);
          end
          // offer a decoy while full, then withdraw it without a handshake
          if (b_tready[k] === 1'b0 && $urandom_range(0, 1) == 1) begin
            b_tvalid[k] = 1'b1;
            b_tdata[k]  = 8'($urandom);
            tick(1);
          end
          b_tvalid[k] = 1'b1;
          b_tdata[k]  = 8'(w);
          n = 0;
          while (b_tready[k] !== 1'b1 && n < 1000) begin
            tick(1);
            n++;
          end
          tick(1);
          exp_q.push_back(8'(w));
          if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL lb%0d_push_timeout: word %0d waited %0d cycles", sb, w, n);
          end
        end
        b_tvalid[k] = 1'b0;
      end
      begin : mon
        int got, idle;
        got = 0;
        idle = 0;
        while (got < 256 && idle < 2000) begin
          @(negedge clk);
          if (b_tx[k] === 1'b0) begin
            logic [7:0] r, e;
            logic ok;
            ok = 1'b1;
            repeat (NT_B / 2) @(negedge clk);
            if (b_tx[k] !== 1'b0) ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
              repeat (NT_B) @(negedge clk);
              r[j] = b_tx[k];
            end
            for (int s = 0; s < sb; s++) begin
              repeat (NT_B) @(negedge clk);
              if (b_tx[k] !== 1'b1) ok = 1'b0;
            end
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL lb%0d_unexpected: got word %h with nothing expected", sb, r);
            end else begin
              e = exp_q.pop_front();
              if ({ok, r} !== {1'b1, e}) begin
                bad++;
                $display("FAIL lb%0d_word: got %h framing_ok=%b required %h framing_ok=1", sb, r, ok, e);
              end
            end
            got++;
            idle = 0;
          end else begin
            idle++;
          end
        end
        total++;
        if (got != 256) begin bad++; $display("FAIL lb%0d_count: got %0d words required 256", sb, got); end
      end
    join
    tick(3 * NT_B);
    total++;
    if ({exp_q.size() == 0, b_busy[k], b_tx[k]} !== 3'b101) begin
      bad++;
      $display("FAIL lb%0d_end: left=%0d busy=%b tx=%b required 0,0,1", sb, exp_q.size(), b_busy[k], b_tx[k]);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      b_tvalid[k] = 1'b0;
      b_tdata[k]  = '0;
    end
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_loopback(0, 1);
    test_loopback(1, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
